// File: rtl/uart_key_decoder.sv
// uart_key_decoder
//   Turns keyboard bytes from uart_rx into game controls for the arcade core.
//   Direction keys hold left/right for HOLD_CLKS clocks after the last byte,
//   so terminal key-repeat keeps the ship moving. Fire is rate-limited by a
//   cooldown. Pause freezes all other controls until the next pause key.
//
// Ports
//   i_clk        system clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_done    byte valid from uart_rx (level; only the rising edge counts)
//   i_rx_data    received byte, sampled on the accept cycle
//   o_left       move left held
//   o_right      move right held
//   o_fire       one-cycle fire pulse
//   o_start      one-cycle start pulse (suppressed while paused)
//   o_pause      pause level, toggled by 'p'/'P'
//   o_err        one-cycle pulse on an unrecognised byte
//   o_last_byte  last accepted byte, whatever its value
module uart_key_decoder #(
    parameter int unsigned HOLD_CLKS     = 12500000,
    parameter int unsigned FIRE_COOLDOWN = 2500000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_done,
    input  logic [7:0] i_rx_data,
    output logic       o_left,
    output logic       o_right,
    output logic       o_fire,
    output logic       o_start,
    output logic       o_pause,
    output logic       o_err,
    output logic [7:0] o_last_byte
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEFT,
        ST_RIGHT
    } dir_state_e;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CLKS - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(FIRE_COOLDOWN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    dir_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cool_q, cool_d;
    logic             done_q;
    logic             pause_q, pause_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic             fire_q, fire_d;
    logic             start_q, start_d;
    logic             err_q, err_d;
    logic [7:0]       last_q, last_d;

    logic accept;
    logic act;          // accepted byte that is allowed to act (not paused)
    logic enter_pause;
    logic key_left, key_right, key_fire, key_start, key_pause, key_err;

    assign accept      = i_rx_done & ~done_q;
    assign act         = accept & ~pause_q;
    assign enter_pause = accept & key_pause & ~pause_q;

    always_comb begin
        key_left  = 1'b0;
        key_right = 1'b0;
        key_fire  = 1'b0;
        key_start = 1'b0;
        key_pause = 1'b0;
        key_err   = 1'b0;
        case (i_rx_data)
            8'h61, 8'h41: key_left  = 1'b1;
            8'h64, 8'h44: key_right = 1'b1;
            8'h20:        key_fire  = 1'b1;
            8'h73, 8'h53: key_start = 1'b1;
            8'h70, 8'h50: key_pause = 1'b1;
            default:      key_err   = 1'b1;
        endcase
    end

    // State register: FSM, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            cool_q  <= '0;
            done_q  <= 1'b0;
            pause_q <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            fire_q  <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cool_q  <= cool_d;
            done_q  <= i_rx_done;
            pause_q <= pause_d;
            left_q  <= left_d;
            right_q <= right_d;
            fire_q  <= fire_d;
            start_q <= start_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Next-state: a fresh direction key overrides expiry; entering pause
    // overrides everything.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_LEFT, ST_RIGHT: begin
                if (hold_q == '0) state_d = ST_IDLE;
                else              hold_d  = hold_q - CNT_ONE;
            end
            default: ;
        endcase
        if (act && key_left) begin
            state_d = ST_LEFT;
            hold_d  = HOLD_LOAD;
        end else if (act && key_right) begin
            state_d = ST_RIGHT;
            hold_d  = HOLD_LOAD;
        end
        if (enter_pause) begin
            state_d = ST_IDLE;
            hold_d  = '0;
        end
    end

    // Output logic: next values of the registered outputs and the cooldown.
    always_comb begin
        cool_d  = (cool_q != '0) ? cool_q - CNT_ONE : cool_q;
        fire_d  = 1'b0;
        start_d = act & key_start;
        err_d   = accept & key_err;
        pause_d = pause_q ^ (accept & key_pause);
        last_d  = accept ? i_rx_data : last_q;
        if (act && key_fire && cool_q == '0) begin
            fire_d = 1'b1;
            cool_d = COOL_LOAD;
        end
        if (enter_pause) cool_d = '0;
        left_d  = (state_d == ST_LEFT);
        right_d = (state_d == ST_RIGHT);
    end

    assign o_left      = left_q;
    assign o_right     = right_q;
    assign o_fire      = fire_q;
    assign o_start     = start_q;
    assign o_pause     = pause_q;
    assign o_err       = err_q;
    assign o_last_byte = last_q;

endmodule

// File: tb/tb_uart_key_decoder.sv
module tb_uart_key_decoder;

    localparam int HOLD = 8;
    localparam int COOL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       o_left, o_right, o_fire, o_start, o_pause, o_err;
    logic [7:0] o_last_byte;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    uart_key_decoder #(
        .HOLD_CLKS(HOLD),
        .FIRE_COOLDOWN(COOL),
        .CNT_W(8)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rx_done(rx_done),
        .i_rx_data(rx_data),
        .o_left(o_left),
        .o_right(o_right),
        .o_fire(o_fire),
        .o_start(o_start),
        .o_pause(o_pause),
        .o_err(o_err),
        .o_last_byte(o_last_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (time-stamp based) ----------------
    // dir: 0 none, 1 left, 2 right; a direction ends at accept cycle + HOLD.
    int  cyc = 0;
    bit  pdone = 0;
    int  dir = 0;
    int  dir_end = 0;
    int  last_fire = 0;
    bit  fire_seen = 0;
    bit  m_pause = 0;
    bit  e_left = 0, e_right = 0, e_fire = 0, e_start = 0, e_err = 0;
    logic [7:0] e_last = 8'h00;

    function automatic int kind(input logic [7:0] b);
        logic [7:0] c;
        c = b;
        if (c >= 8'h41 && c <= 8'h5A) c = c + 8'h20;
        case (c)
            8'h61: return 1;
            8'h64: return 2;
            8'h20: return 3;
            8'h73: return 4;
            8'h70: return 5;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; pdone = 0; dir = 0; fire_seen = 0; m_pause = 0;
            e_left = 0; e_right = 0; e_fire = 0; e_start = 0; e_err = 0;
            e_last = 8'h00;
        end else begin
            cyc++;
            e_fire = 0; e_start = 0; e_err = 0;
            if (rx_done && !pdone) begin
                e_last = rx_data;
                case (kind(rx_data))
                    1, 2: if (!m_pause) begin
                        dir = kind(rx_data);
                        dir_end = cyc + HOLD;
                    end
                    3: if (!m_pause && (!fire_seen || cyc - last_fire >= COOL)) begin
                        e_fire = 1;
                        last_fire = cyc;
                        fire_seen = 1;
                    end
                    4: if (!m_pause) e_start = 1;
                    5: begin
                        m_pause = !m_pause;
                        if (m_pause) begin
                            dir = 0;
                            fire_seen = 0;
                        end
                    end
                    default: e_err = 1;
                endcase
            end
            pdone = rx_done;
            if (dir != 0 && cyc >= dir_end) dir = 0;
            e_left  = (dir == 1);
            e_right = (dir == 2);
        end
    end

    // ---------------- per-cycle compare + pulse counters ----------------
    int n_fire = 0, n_start = 0, n_err = 0, n_left = 0, n_right = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("left",  o_left,  e_left);
            check("right", o_right, e_right);
            check("fire",  o_fire,  e_fire);
            check("start", o_start, e_start);
            check("pause", o_pause, m_pause);
            check("err",   o_err,   e_err);
            check("last",  o_last_byte, e_last);
            check("both_dir", o_left & o_right, 0);
            n_fire  += o_fire;
            n_start += o_start;
            n_err   += o_err;
            n_left  += o_left;
            n_right += o_right;
        end
    end

    task automatic clr_counts();
        n_fire = 0; n_start = 0; n_err = 0; n_left = 0; n_right = 0;
    endtask

    task automatic send(input logic [7:0] d, input int n);
        @(negedge clk);
        rx_data = d;
        rx_done = 1'b1;
        repeat (n) @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_left", o_left, 0);
        check("rst_last", o_last_byte, 0);
        #20;
        rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // single left key: exactly HOLD cycles
        clr_counts();
        send(8'h61, 1);
        idle(12);
        check("t1_left_cycles", n_left, 8);
        check("t1_right_cycles", n_right, 0);
        check("t1_last", o_last_byte, 8'h61);

        // left then right three cycles later
        clr_counts();
        send(8'h41, 1);
        idle(1);
        send(8'h44, 1);
        idle(12);
        check("t2_left_cycles", n_left, 3);
        check("t2_right_cycles", n_right, 8);

        // fire at 0, 2, 5: cycle 2 dropped
        clr_counts();
        send(8'h20, 1);
        send(8'h20, 1);
        idle(1);
        send(8'h20, 1);
        idle(6);
        check("t3_fire_pulses", n_fire, 2);
        check("t3_err_pulses", n_err, 0);

        // held done gives one start; unknown byte gives one err
        clr_counts();
        send(8'h53, 10);
        idle(3);
        check("t4_start_pulses", n_start, 1);
        send(8'h7A, 1);
        idle(3);
        check("t4_err_pulses", n_err, 1);
        check("t4_last", o_last_byte, 8'h7A);

        // pause clears right, blocks fire/start, unpause
        clr_counts();
        send(8'h64, 1);
        idle(2);
        send(8'h70, 1);
        idle(1);
        check("t5_paused", o_pause, 1);
        check("t5_right_cleared", o_right, 0);
        send(8'h20, 1);
        send(8'h73, 1);
        idle(3);
        check("t5_fire_blocked", n_fire, 0);
        check("t5_start_blocked", n_start, 0);
        check("t5_no_err", n_err, 0);
        send(8'h50, 1);
        idle(2);
        check("t5_unpaused", o_pause, 0);

        // async reset mid-hold
        clr_counts();
        send(8'h61, 1);
        idle(2);
        check("t6_left_before_rst", o_left, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_left", o_left, 0);
        check("t6_rst_last", o_last_byte, 0);
        check("t6_rst_pause", o_pause, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        idle(12);
        check("t6_no_residual_left", n_left, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
